// File: rtl/hex8_disp_arbiter.sv
// hex8_disp_arbiter: shares the 8-digit hex display between three sources
// using round-robin grants with a minimum hold and a maximum ownership time.
module hex8_disp_arbiter #(
   parameter int unsigned HOLD_CYC  = 50_000_000,
   parameter int unsigned MAX_CYC   = 150_000_000,
   parameter int unsigned CW        = 28,
   parameter logic [31:0] IDLE_DATA = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [2:0]  req,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   output logic [31:0] disp_data,
   output logic [2:0]  grant,
   output logic        busy,
   output logic        switch_pulse
);

   typedef enum logic {IDLE, OWN} state_t;

   localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] MAX_M1  = CW'(MAX_CYC - 1);

   state_t        state_q, state_d;
   logic [2:0]    grant_q, grant_d;
   logic [1:0]    last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   disp_q, disp_d;
   logic          pulse_q, pulse_d;

   logic [2:0]    own_oh;
   logic [2:0]    others;
   logic          rel;
   logic          pre;
   logic [31:0]   sel;

   // First set bit at or after (from+1) mod 3, wrapping; from itself is last.
   function automatic logic [1:0] rr_pick(input logic [2:0] r,
                                          input logic [1:0] from);
      logic [1:0] idx;
      rr_pick = from;
      for (int k = 3; k >= 1; k--) begin
         idx = 2'((int'(from) + k) % 3);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      own_oh  = 3'b001 << last_q;
      others  = req & ~own_oh;
      rel     = 1'b0;
      pre     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               last_d  = rr_pick(req, last_q);
               grant_d = 3'b001 << last_d;
               cnt_d   = '0;
               state_d = OWN;
            end
         end
         OWN: begin
            cnt_d = (cnt_q == MAX_M1) ? cnt_q : cnt_q + 1'b1;
            rel   = (cnt_q >= HOLD_M1) && !(|(req & own_oh));
            pre   = (cnt_q == MAX_M1) && (|(req & own_oh)) && (|others);
            if (rel || pre) begin
               cnt_d = '0;
               if (|others) begin
                  last_d  = rr_pick(others, last_q);
                  grant_d = 3'b001 << last_d;
               end else begin
                  grant_d = '0;
                  state_d = IDLE;
               end
            end
         end
         default: ;
      endcase
   end

   // The display word follows the post-edge owner, so it never lags grant.
   always_comb begin
      case (last_d)
         2'd0:    sel = data0;
         2'd1:    sel = data1;
         default: sel = data2;
      endcase
      disp_d  = (grant_d == 3'b000) ? IDLE_DATA : sel;
      pulse_d = (grant_d != grant_q);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= 2'd2;
         cnt_q   <= '0;
         disp_q  <= IDLE_DATA;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         pulse_q <= pulse_d;
      end
   end

   always_ff @(posedge Clk) begin
      assert (HOLD_CYC != 0 && MAX_CYC > HOLD_CYC &&
              (64'(1) << CW) >= 64'(MAX_CYC));
   end

   assign disp_data    = disp_q;
   assign grant        = grant_q;
   assign busy         = |grant_q;
   assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_hex8_disp_arbiter.sv
// tb_hex8_disp_arbiter: directed per-cycle vectors plus hand-written
// sequences for saturation, live data and asynchronous reset.
module tb_hex8_disp_arbiter;

   localparam logic [31:0] IDLE = 32'hDEAD_BEEF;
   localparam logic [31:0] D0   = 32'h1234_5678;
   localparam logic [31:0] D1   = 32'hAAAA_1111;
   localparam logic [31:0] D2   = 32'h5555_CCCC;

   logic        Clk;
   logic        Rst_n;
   logic [2:0]  req;
   logic [31:0] data0, data1, data2;
   logic [31:0] disp_data;
   logic [2:0]  grant;
   logic        busy;
   logic        switch_pulse;

   int checks;
   int failures;

   typedef struct {
      logic       rst;
      logic [2:0] req;
      logic [2:0] g;
      logic       p;
   } vec_t;

   vec_t vecs[$];

   hex8_disp_arbiter #(
      .HOLD_CYC (4),
      .MAX_CYC  (10),
      .CW       (4),
      .IDLE_DATA(IDLE)
   ) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .req         (req),
      .data0       (data0),
      .data1       (data1),
      .data2       (data2),
      .disp_data   (disp_data),
      .grant       (grant),
      .busy        (busy),
      .switch_pulse(switch_pulse)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_disp(input logic [2:0] g);
      case (g)
         3'b001:  return data0;
         3'b010:  return data1;
         3'b100:  return data2;
         default: return IDLE;
      endcase
   endfunction

   task automatic add(input logic r, input logic [2:0] rq,
                      input logic [2:0] g, input logic p, input int n);
      for (int k = 0; k < n; k++) begin
         vecs.push_back('{r && (k == 0), rq, g, p});
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [2:0] g,
                          input logic p);
      chk({tag, " grant"}, 32'(grant), 32'(g));
      chk({tag, " pulse"}, 32'(switch_pulse), 32'(p));
      chk({tag, " busy"}, 32'(busy), 32'(|g));
      chk({tag, " disp"}, disp_data, exp_disp(g));
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      req   = 3'b000;
      #2;
      chk_out("reset", 3'b000, 1'b0);
      @(negedge Clk);
      Rst_n = 1'b1;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      checks   = 0;
      failures = 0;
      Rst_n    = 1'b1;
      req      = 3'b000;
      data0    = D0;
      data1    = D1;
      data2    = D2;

      // single short request
      add(1, 3'b001, 3'b001, 1, 1);
      add(0, 3'b000, 3'b001, 0, 3);
      add(0, 3'b000, 3'b000, 1, 1);
      add(0, 3'b000, 3'b000, 0, 1);
      // all three, each dropping one cycle after its grant
      add(1, 3'b111, 3'b001, 1, 1);
      add(0, 3'b110, 3'b001, 0, 3);
      add(0, 3'b110, 3'b010, 1, 1);
      add(0, 3'b100, 3'b010, 0, 3);
      add(0, 3'b100, 3'b100, 1, 1);
      add(0, 3'b000, 3'b100, 0, 3);
      add(0, 3'b000, 3'b000, 1, 1);
      add(0, 3'b000, 3'b000, 0, 1);
      // source 0 hogs, source 1 contends
      add(1, 3'b001, 3'b001, 1, 1);
      add(0, 3'b001, 3'b001, 0, 1);
      add(0, 3'b011, 3'b001, 0, 8);
      add(0, 3'b011, 3'b010, 1, 1);
      add(0, 3'b001, 3'b010, 0, 3);
      add(0, 3'b001, 3'b001, 1, 1);
      add(0, 3'b000, 3'b001, 0, 1);

      @(posedge Clk);
      #1;
      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         req = vecs[i].req;
         step();
         chk_out($sformatf("v%0d", i), vecs[i].g, vecs[i].p);
      end

      // lone owner runs past the ownership limit
      do_reset();
      req = 3'b010;
      for (int i = 0; i < 30; i++) begin
         step();
         chk($sformatf("solo%0d grant", i), 32'(grant), 32'(3'b010));
         chk($sformatf("solo%0d pulse", i), 32'(switch_pulse),
             32'(i == 0));
      end
      chk("solo cnt sat", 32'(dut.cnt_q), 32'd9);
      data1 = 32'hCAFE_0001;
      step();
      chk("live data", disp_data, 32'hCAFE_0001);
      req = 3'b011;
      step();
      chk_out("sat preempt", 3'b001, 1'b1);

      // asynchronous reset in the middle of a grant
      do_reset();
      req = 3'b100;
      step();
      chk_out("mid g0", 3'b100, 1'b1);
      step();
      step();
      chk_out("mid g2", 3'b100, 1'b0);
      Rst_n = 1'b0;
      req   = 3'b111;
      #2;
      chk_out("mid reset", 3'b000, 1'b0);
      @(negedge Clk);
      Rst_n = 1'b1;
      step();
      chk_out("post reset", 3'b001, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hex8_disp_arbiter.md
Name: hex8_disp_arbiter

Overview:
Shares the 8-digit hex display driver between three requesters: status, debug and user sources. Each requester offers a 32-bit nibble-packed word, one hex digit per nibble, digit 0 in bits [3:0]. The block grants the display to one requester at a time using round-robin order, a minimum on-screen hold time and a maximum ownership time. Its disp_data output feeds the display driver's disp_data input directly. The block runs on the same 50 MHz clock as the driver.

Parameters:
HOLD_CYC, 50_000_000, minimum cycles a grant is held (1 s); must be >= 1.
MAX_CYC, 150_000_000, ownership cycles after which a contended grant is rotated; must be > HOLD_CYC.
CW, 28, width of the ownership counter; must satisfy 2^CW >= MAX_CYC.
IDLE_DATA, 32'h0000_0000, word shown while no requester owns the display.

Ports:
Clk  input  1  system clock, 50 MHz.
Rst_n  input  1  asynchronous active-low reset.
req  input  3  request per source; bit i belongs to data_i.
data0  input  32  display word for source 0.
data1  input  32  display word for source 1.
data2  input  32  display word for source 2.
disp_data  output  32  registered word to the display driver.
grant  output  3  registered one-hot grant; 000 when idle.
busy  output  1  |grant.
switch_pulse  output  1  registered; high for one cycle after any change of grant.

Behaviour:
- Clocking and reset: single clock Clk. Rst_n is asynchronous and active-low, and it clears all state immediately, including mid-grant.
- Reset values: state=IDLE, grant=000, busy=0, switch_pulse=0, disp_data=IDLE_DATA, cnt=0, last=2. last=2 makes source 0 the first round-robin candidate.
- Round-robin pick: search from index (last+1) mod 3 upward with wrap-around. Take the first index whose req bit is set, excluding the current owner when rotating.
- State IDLE:
  - On each edge, if req != 000: grant <= onehot(pick), cnt <= 0, last <= pick, state <= OWN.
  - Latency is one cycle from req high to grant high.
- State OWN:
  - cnt increments by 1 per edge and saturates at MAX_CYC-1.
  - Release: when cnt >= HOLD_CYC-1 and req[owner]=0:
    - If any other req bit is set, grant moves directly to the next round-robin requester on that edge, with no IDLE cycle, and cnt <= 0.
    - Otherwise grant <= 000 and state <= IDLE.
  - Preempt: when cnt == MAX_CYC-1, req[owner]=1 and any other req bit is set, rotate to the next requester on that edge with cnt <= 0. With no contender the owner keeps the grant indefinitely and cnt stays saturated.
  - Hold guarantee: a requester that drops req before HOLD_CYC cycles keeps the grant for exactly HOLD_CYC cycles. Its data stays on the display throughout.
  - Simultaneous release and preempt conditions follow the release rule; the outcome is the same rotation.
- disp_data:
  - Registered each edge as data[owner], using the owner after the same edge's grant update. disp_data therefore lags grant by zero cycles and tracks live data changes one cycle late.
  - Equals IDLE_DATA whenever grant=000.
- switch_pulse: high on the cycle after an edge where grant changed value, including 000->x, x->y and x->000. Never high for two consecutive cycles unless grant changes on consecutive edges.
- Illegal parameters (HOLD_CYC=0, MAX_CYC<=HOLD_CYC): behaviour undefined, to be flagged by simulation assertion.

Test Plan (HOLD_CYC=4, MAX_CYC=10, CW=4, IDLE_DATA=32'hDEAD_BEEF):
1. Reset: assert Rst_n=0 asynchronously mid-cycle -> grant=000, busy=0, switch_pulse=0, disp_data=DEADBEEF immediately, with no clock edge required.
2. Single request held short: req=001 for 1 cycle, data0=32'h1234_5678 -> grant=001 one edge later, disp_data=12345678; grant held exactly 4 cycles, then grant=000 and disp_data=DEADBEEF; switch_pulse pulses twice.
3. All requesters from reset: req=111 held, each source drops req 1 cycle after its grant -> grant sequence 001, 010, 100, each 4 cycles, with no idle cycles between them.
4. Hogging: req=001 held continuously, req[1] raised 2 cycles after grant -> grant stays 001 for 10 cycles, then 010; source 0 gets its next grant after source 1 releases.
5. Owner alone past MAX_CYC: req=010 held for 30 cycles with no contender -> grant=010 throughout, switch_pulse only once, cnt saturated at 9.
6. Reset mid-grant: grant=100 at cnt=2, pulse Rst_n low, release with req=111 -> first grant after reset is 001, confirming last=2 is restored.
